// File: rtl/sha256_nonce_scheduler_if.sv
// sha256_nonce_scheduler_if: request/response handshake between the nonce scheduler and the SHA-256 core
//   core_start  one-cycle pass request (scheduler -> core)
//   core_pass   0 = header pass, 1 = rehash pass (scheduler -> core)
//   core_nonce  nonce under test (scheduler -> core)
//   core_done   one-cycle pass-complete pulse (core -> scheduler)
//   core_hash   digest, valid with core_done (core -> scheduler)
interface sha256_nonce_scheduler_if #(parameter int NONCE_W = 32);
  logic               core_start;
  logic               core_pass;
  logic [NONCE_W-1:0] core_nonce;
  logic               core_done;
  logic [255:0]       core_hash;
  modport master (output core_start, core_pass, core_nonce, input core_done, core_hash);
  modport slave  (input core_start, core_pass, core_nonce, output core_done, core_hash);
endinterface

// File: rtl/sha256_nonce_scheduler.sv
// sha256_nonce_scheduler: sweeps a nonce range through a double SHA-256 and reports the first digest below target
//   clk, reset_n               clock, asynchronous active-low reset
//   start, abort               sweep start pulse (IDLE/terminal only), level abort to IDLE
//   nonce_start, nonce_end     inclusive nonce range, sampled on start
//   target                     strict upper bound for a winning digest, sampled on start
//   core                       handshake to the hash core (master side)
//   busy, found, found_nonce   sweep in progress, winner located and its nonce
//   exhausted, error           range finished without winner, core timed out
module sha256_nonce_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int NONCE_W        = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NONCE_W-1:0]        nonce_start,
  input  logic [NONCE_W-1:0]        nonce_end,
  input  logic [255:0]              target,
  sha256_nonce_scheduler_if.master  core,
  output logic                      busy,
  output logic                      found,
  output logic [NONCE_W-1:0]        found_nonce,
  output logic                      exhausted,
  output logic                      error
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, CHECK, FOUND, EXHAUSTED, ERROR} state_t;
  state_t state, state_n;
  logic [NONCE_W-1:0] nonce, nonce_n, end_q, end_n, found_nonce_n;
  logic [255:0] target_q, target_n, hash_q, hash_n;
  logic [CW-1:0] cnt, cnt_n;
  logic found_n, exhausted_n, error_n, idle_like, timeout;
  assign idle_like       = state inside {IDLE, FOUND, EXHAUSTED, ERROR};
  assign busy            = !idle_like;
  assign core.core_start = state inside {ISSUE0, ISSUE1};
  assign core.core_pass  = state inside {ISSUE1, WAIT1};
  assign core.core_nonce = nonce;
  // the counter hits TIMEOUT_CYCLES on the same edge that leaves for ERROR
  assign timeout = (state inside {WAIT0, WAIT1}) && !core.core_done && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n       = state;
    nonce_n       = nonce;
    end_n         = end_q;
    target_n      = target_q;
    hash_n        = hash_q;
    found_n       = found;
    found_nonce_n = found_nonce;
    exhausted_n   = exhausted;
    error_n       = error;
    cnt_n         = core.core_start ? '0 : (cnt == CW'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;
    if (abort)
      state_n = IDLE;
    else if (idle_like) begin
      if (start) begin
        end_n       = nonce_end;
        target_n    = target;
        found_n     = 1'b0;
        error_n     = 1'b0;
        exhausted_n = nonce_start > nonce_end;
        nonce_n     = (nonce_start > nonce_end) ? nonce : nonce_start;
        state_n     = (nonce_start > nonce_end) ? EXHAUSTED : ISSUE0;
      end
    end else if (timeout) begin
      state_n = ERROR;
      error_n = 1'b1;
    end else
      case (state)
        ISSUE0: state_n = WAIT0;
        ISSUE1: state_n = WAIT1;
        WAIT0:  state_n = core.core_done ? ISSUE1 : WAIT0;
        WAIT1: if (core.core_done) begin
          hash_n  = core.core_hash;
          state_n = CHECK;
        end
        CHECK: if (hash_q < target_q) begin
          found_n       = 1'b1;
          found_nonce_n = nonce;
          state_n       = FOUND;
        end else if (nonce == end_q) begin
          exhausted_n = 1'b1;
          state_n     = EXHAUSTED;
        end else begin
          nonce_n = nonce + 1'b1;
          state_n = ISSUE0;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      nonce       <= '0;
      end_q       <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      cnt         <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
      exhausted   <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      nonce       <= nonce_n;
      end_q       <= end_n;
      target_q    <= target_n;
      hash_q      <= hash_n;
      cnt         <= cnt_n;
      found       <= found_n;
      found_nonce <= found_nonce_n;
      exhausted   <= exhausted_n;
      error       <= error_n;
    end
endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// tb_sha256_nonce_scheduler: table-driven sweeps with a stub hash core and a core-request scoreboard
module tb_sha256_nonce_scheduler;
  localparam logic [255:0] H255 = 256'd1 << 255;
  localparam logic [255:0] ONES = ~256'd0;
  typedef struct {
    logic [31:0]  ns, ne;
    logic [255:0] tg;
    logic         win_en;
    logic [31:0]  win;
    logic [255:0] win_hash, lose_hash;
    int           lat;
    int           exp_pulses;
    logic         exp_found, exp_exh, chk_nonce;
    logic [31:0]  exp_nonce;
  } vec_t;
  typedef struct {
    logic        pass;
    logic [31:0] nonce;
  } exp_t;
  logic clk = 0, reset_n = 1, start = 0, abort = 0;
  logic [31:0] nonce_start = 0, nonce_end = 0, found_nonce;
  logic [255:0] target = 0;
  logic busy, found, exhausted, error;
  logic win_en = 0, hang = 0, abort_on_done = 0;
  logic [31:0] win_nonce = 0;
  logic [255:0] win_hash = 0, lose_hash = 0;
  int lat = 1, pulses = 0, zero_pulses = 0, n_checks = 0, n_fail = 0;
  exp_t sb[$];
  vec_t vec[6];
  sha256_nonce_scheduler_if #(.NONCE_W(32)) core_if();
  sha256_nonce_scheduler #(.TIMEOUT_CYCLES(16), .NONCE_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .core(core_if), .busy(busy), .found(found), .found_nonce(found_nonce),
    .exhausted(exhausted), .error(error));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_pair(input logic [31:0] n);
    exp_t e;
    e.nonce = n;
    e.pass = 1'b0;
    sb.push_back(e);
    e.pass = 1'b1;
    sb.push_back(e);
  endtask
  task automatic run_sweep(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tg);
    @(posedge clk); #1;
    nonce_start = ns; nonce_end = ne; target = tg; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_idle(input int max);
    int i;
    i = 0;
    while (busy && i < max) begin
      @(posedge clk); #1;
      i++;
    end
    check("idle_wait", busy, 0);
  endtask
  // stub core: answers each request after lat cycles; pass-0 digest of 0 would win if wrongly captured
  initial begin
    logic p;
    logic [31:0] n;
    core_if.core_done = 0;
    core_if.core_hash = '0;
    forever begin
      @(negedge clk);
      if (core_if.core_start && !hang) begin
        p = core_if.core_pass;
        n = core_if.core_nonce;
        repeat (lat) @(posedge clk);
        #1;
        core_if.core_done = 1;
        core_if.core_hash = !p ? '0 : (win_en && n == win_nonce) ? win_hash : lose_hash;
        if (p && abort_on_done) abort = 1;
        @(posedge clk); #1;
        core_if.core_done = 0;
        core_if.core_hash = '0;
        if (abort_on_done) abort = 0;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (reset_n && core_if.core_start) begin
      exp_t e;
      pulses++;
      if (core_if.core_nonce == 0) zero_pulses++;
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("core_req", {core_if.core_pass, core_if.core_nonce}, {e.pass, e.nonce});
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec[0] = '{32'd5, 32'd9, H255, 1'b1, 32'd7, H255 - 1, H255, 1, 6, 1'b1, 1'b0, 1'b1, 32'd7};
    vec[1] = '{32'd0, 32'd3, 256'd0, 1'b0, 32'd0, 256'd0, 256'd0, 2, 8, 1'b0, 1'b1, 1'b1, 32'd3};
    vec[2] = '{32'd10, 32'd2, 256'd0, 1'b0, 32'd0, 256'd0, 256'd0, 1, 0, 1'b0, 1'b1, 1'b0, 32'd0};
    vec[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'd0, 1'b0, 32'd0, 256'd0, ONES, 1, 4, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vec[4] = '{32'd100, 32'd100, 256'h1000, 1'b1, 32'd100, 256'hFFF, ONES, 3, 2, 1'b1, 1'b0, 1'b1, 32'd100};
    vec[5] = '{32'd20, 32'd22, H255 - 1, 1'b1, 32'd22, H255 - 2, ONES, 1, 6, 1'b1, 1'b0, 1'b1, 32'd22};
    #1 reset_n = 0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_found", found, 0);
    check("rst_found_nonce", found_nonce, 0);
    check("rst_exhausted", exhausted, 0);
    check("rst_error", error, 0);
    check("rst_core_start", core_if.core_start, 0);
    check("rst_core_pass", core_if.core_pass, 0);
    check("rst_core_nonce", core_if.core_nonce, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      vec_t r;
      r = vec[i];
      win_en = r.win_en; win_nonce = r.win; win_hash = r.win_hash; lose_hash = r.lose_hash; lat = r.lat;
      pulses = 0; zero_pulses = 0;
      if (r.ns <= r.ne)
        for (longint n = longint'(r.ns); n <= longint'(r.win_en ? r.win : r.ne); n++) push_pair(32'(n));
      run_sweep(r.ns, r.ne, r.tg);
      if (r.exp_pulses == 0) check("inv_exh_1cyc", {busy, exhausted}, 2'b01);
      wait_idle(400);
      check("found", found, r.exp_found);
      check("exhausted", exhausted, r.exp_exh);
      check("error", error, 0);
      check("pulses", pulses, r.exp_pulses);
      check("sb_drained", sb.size(), 0);
      check("zero_nonce_pulses", zero_pulses, (r.ns == 0 && r.ns <= r.ne) ? 2 : 0);
      if (r.exp_found) check("found_nonce", found_nonce, r.win);
      if (r.chk_nonce) check("core_nonce_end", core_if.core_nonce, r.exp_nonce);
      sb.delete();
      repeat (2) @(posedge clk);
    end
    // core never answers: ERROR exactly 16 cycles after WAIT0 entry
    hang = 1; pulses = 0;
    push_pair(32'd0);
    void'(sb.pop_back());
    run_sweep(32'd0, 32'd0, 256'd0);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k == 16) check("err_before_timeout", {busy, error}, 2'b10);
    end
    check("timeout_error", error, 1);
    check("timeout_busy", busy, 0);
    check("timeout_pulses", pulses, 1);
    check("timeout_sb", sb.size(), 0);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("abort_keeps_error", {busy, error}, 2'b01);
    hang = 0;
    // abort coincident with the pass-1 done that would have won
    win_en = 1; win_nonce = 0; win_hash = 256'd0; lose_hash = ONES; lat = 1; abort_on_done = 1; pulses = 0;
    push_pair(32'd0);
    run_sweep(32'd0, 32'd10, H255);
    wait_idle(100);
    check("abort_found", found, 0);
    check("abort_flags", {exhausted, error}, 2'b00);
    check("abort_core_outs", {core_if.core_start, core_if.core_pass}, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    check("abort_pulses", pulses, 2);
    check("abort_sb", sb.size(), 0);
    abort_on_done = 0;
    // asynchronous reset in the middle of a sweep
    win_en = 0; lose_hash = ONES; lat = 3;
    for (int n = 3; n <= 9; n++) push_pair(32'(n));
    run_sweep(32'd3, 32'd9, 256'd0);
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_found_nonce", found_nonce, 22);
    reset_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_core", {core_if.core_start, core_if.core_pass, core_if.core_nonce}, 0);
    check("arst_found", {found, found_nonce}, 0);
    check("arst_flags", {exhausted, error}, 2'b00);
    sb.delete();
    repeat (6) @(posedge clk);
    #1 reset_n = 1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", {busy, core_if.core_start}, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
